// File: rtl/turn_score_writer.sv
// Turn-indexed write side for the player position counters: routes each step to the
// player whose turn it is, advances the turn, and freezes the game on a win.

module turn_score_lane #(
  parameter int CNT_W     = 5,
  parameter int STEP_W    = 3,
  parameter int WIN_SCORE = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              upd,
  input  logic [STEP_W-1:0] step_amt,
  output logic [CNT_W-1:0]  cnt,
  output logic              hit
);
  localparam logic [CNT_W:0]   WIN_EXT = (CNT_W+1)'(WIN_SCORE);
  localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WIN_SCORE);

  logic [CNT_W:0] sum;

  // One extra bit so a near-max counter plus a step cannot wrap before the compare.
  assign sum = {1'b0, cnt} + (CNT_W+1)'(step_amt);
  assign hit = (sum >= WIN_EXT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (upd) cnt <= hit ? WIN_CNT : sum[CNT_W-1:0];
  end
endmodule

module turn_score_writer #(
  parameter int CNT_W     = 5,
  parameter int STEP_W    = 3,
  parameter int WIN_SCORE = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        N,
  input  logic              step_valid,
  input  logic [STEP_W-1:0] step_amt,
  output logic [1:0]        N_q,
  output logic [1:0]        T,
  output logic [CNT_W-1:0]  p1_cnt,
  output logic [CNT_W-1:0]  p2_cnt,
  output logic [CNT_W-1:0]  p3_cnt,
  output logic [CNT_W-1:0]  p4_cnt,
  output logic              busy,
  output logic              game_over,
  output logic [2:0]        winner
);
  localparam int NUM_LANES = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                       state;
  logic [NUM_LANES-1:0][CNT_W-1:0]  cnt;
  logic [NUM_LANES-1:0]             hit;
  logic [1:0]                       last, tgt;
  logic                             start_ok, step_ok, win;

  assign last     = N_q + 2'd1;
  // Same mapping as the read mux: the last turn index belongs to p1, others to p(T+2).
  assign tgt      = (T == last) ? 2'd0 : T + 2'd1;
  assign start_ok = start && (N != 2'b11);
  assign step_ok  = step_valid && (state == S_PLAY) && !start_ok;
  assign win      = hit[tgt];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    turn_score_lane #(.CNT_W(CNT_W), .STEP_W(STEP_W), .WIN_SCORE(WIN_SCORE)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr      (start_ok),
      .upd      (step_ok && (tgt == 2'(i))),
      .step_amt (step_amt),
      .cnt      (cnt[i]),
      .hit      (hit[i])
    );
  end

  assign p1_cnt = cnt[0];
  assign p2_cnt = cnt[1];
  assign p3_cnt = cnt[2];
  assign p4_cnt = cnt[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      N_q       <= 2'd0;
      T         <= 2'd0;
      winner    <= 3'd0;
      busy      <= 1'b0;
      game_over <= 1'b0;
    end else if (start_ok) begin
      state     <= S_PLAY;
      N_q       <= N;
      T         <= 2'd0;
      winner    <= 3'd0;
      busy      <= 1'b1;
      game_over <= 1'b0;
    end else if (step_ok) begin
      if (win) begin
        // T stays on the winner's turn.
        state     <= S_DONE;
        winner    <= {1'b0, tgt} + 3'd1;
        busy      <= 1'b0;
        game_over <= 1'b1;
      end else begin
        T <= (T == last) ? 2'd0 : T + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_turn_score_writer.sv
// Directed bench for turn_score_writer: turn routing, wrap, win/saturation, restart, reset.

module tb_turn_score_writer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] N = 2'b00;
  logic       step_valid = 1'b0;
  logic [2:0] step_amt = 3'd0;
  logic [1:0] N_q, T;
  logic [4:0] p1_cnt, p2_cnt, p3_cnt, p4_cnt;
  logic       busy, game_over;
  logic [2:0] winner;

  int checks = 0;
  int errors = 0;

  turn_score_writer #(.CNT_W(5), .STEP_W(3), .WIN_SCORE(20)) dut (
    .clk(clk), .rst(rst), .start(start), .N(N),
    .step_valid(step_valid), .step_amt(step_amt),
    .N_q(N_q), .T(T),
    .p1_cnt(p1_cnt), .p2_cnt(p2_cnt), .p3_cnt(p3_cnt), .p4_cnt(p4_cnt),
    .busy(busy), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_step(input int a);
    @(negedge clk); step_valid = 1'b1; step_amt = 3'(a);
    @(negedge clk); step_valid = 1'b0; step_amt = 3'd0;
  endtask

  task automatic do_start(input logic [1:0] n);
    @(negedge clk); start = 1'b1; N = n;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic chk_cnts(input string tag, input int a, input int b, input int c, input int d);
    chk({tag, ".p1"}, int'(p1_cnt), a);
    chk({tag, ".p2"}, int'(p2_cnt), b);
    chk({tag, ".p3"}, int'(p3_cnt), c);
    chk({tag, ".p4"}, int'(p4_cnt), d);
  endtask

  initial begin
    #12 rst = 1'b0;
    @(negedge clk);
    chk_cnts("rst", 0, 0, 0, 0);
    chk("rst.T", int'(T), 0);
    chk("rst.Nq", int'(N_q), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.over", int'(game_over), 0);
    chk("rst.win", int'(winner), 0);

    // step while IDLE is ignored
    do_step(5);
    chk("idle_step.p2", int'(p2_cnt), 0);

    // two players
    do_start(2'b00);
    chk("n00.busy", int'(busy), 1);
    do_step(3);
    chk("n00.s1.p2", int'(p2_cnt), 3);
    chk("n00.s1.T", int'(T), 1);
    do_step(4);
    chk("n00.s2.p1", int'(p1_cnt), 4);
    chk("n00.s2.T", int'(T), 0);
    do_step(5);
    chk_cnts("n00.s3", 4, 8, 0, 0);
    chk("n00.s3.T", int'(T), 1);

    // four players, full rotation (restart from PLAY)
    do_start(2'b10);
    chk_cnts("n10.clr", 0, 0, 0, 0);
    chk("n10.Nq", int'(N_q), 2);
    do_step(1); do_step(2); do_step(3);
    chk("n10.T3", int'(T), 3);
    do_step(4);
    chk_cnts("n10.rot", 4, 1, 2, 3);
    chk("n10.rot.T", int'(T), 0);
    do_step(7);
    chk("n10.s5.p2", int'(p2_cnt), 8);
    chk("n10.s5.T", int'(T), 1);

    // three players, win with saturation
    do_start(2'b01);
    for (int r = 0; r < 3; r++) begin
      do_step(6); do_step(0); do_step(0);
    end
    chk("n01.pre.p2", int'(p2_cnt), 18);
    chk("n01.pre.T", int'(T), 0);
    do_step(7);
    chk("win.p2", int'(p2_cnt), 20);
    chk("win.winner", int'(winner), 2);
    chk("win.over", int'(game_over), 1);
    chk("win.busy", int'(busy), 0);
    chk("win.T", int'(T), 0);
    do_step(3);
    chk_cnts("done.step", 0, 20, 0, 0);
    chk("done.T", int'(T), 0);
    do_start(2'b11);
    chk("done.n11.over", int'(game_over), 1);
    chk("done.n11.Nq", int'(N_q), 1);

    // restart from DONE clears winner
    do_start(2'b00);
    chk("restart.win", int'(winner), 0);
    chk("restart.busy", int'(busy), 1);
    chk("restart.p2", int'(p2_cnt), 0);

    // invalid start from IDLE
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    do_start(2'b11);
    chk("n11.busy", int'(busy), 0);
    chk("n11.Nq", int'(N_q), 0);

    // start beats step in the same cycle
    do_start(2'b00);
    do_step(2); do_step(3);
    chk("pre.p1", int'(p1_cnt), 3);
    @(negedge clk); start = 1'b1; N = 2'b01; step_valid = 1'b1; step_amt = 3'd6;
    @(negedge clk); start = 1'b0; step_valid = 1'b0; step_amt = 3'd0;
    chk_cnts("both", 0, 0, 0, 0);
    chk("both.T", int'(T), 0);
    chk("both.Nq", int'(N_q), 1);

    // async reset mid-game, between edges
    do_step(4); do_step(2);
    chk("mid.p3", int'(p3_cnt), 2);
    @(posedge clk); #2 rst = 1'b1; #1;
    chk_cnts("arst", 0, 0, 0, 0);
    chk("arst.T", int'(T), 0);
    chk("arst.busy", int'(busy), 0);
    chk("arst.Nq", int'(N_q), 0);
    @(negedge clk); rst = 1'b0;
    do_step(5);
    chk("arst.step.p2", int'(p2_cnt), 0);
    chk("arst.step.T", int'(T), 0);
    chk("arst.step.busy", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/turn_score_writer.md
Name: turn_score_writer

Overview:
- Write-side counterpart of the turn-indexed player-count read mux.
- Holds the per-player position counters (p1..p4) and the turn index T.
- Routes each step update to the player whose turn it is, using the same T/N-to-player mapping the read mux uses, then advances the turn.
- Detects the winning player and freezes the game until the next start.

Parameters:
- CNT_W, 5, width of each player counter (matches 5-bit count buses)
- STEP_W, 3, width of step amount
- WIN_SCORE, 20, counter value at or above which a player wins; counters saturate here

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse: begin a new game with player-count code N
- N  input  2  player-count code: 2'b00=2 players, 2'b01=3, 2'b10=4, 2'b11 invalid
- step_valid  input  1  one-cycle pulse: current player moves step_amt
- step_amt  input  STEP_W  move amount, 0 allowed
- N_q  output  2  player-count code latched at start
- T  output  2  current turn index
- p1_cnt, p2_cnt, p3_cnt, p4_cnt  output  CNT_W each  player counters
- busy  output  1  high in PLAY
- game_over  output  1  high in DONE
- winner  output  3  winning player number 1..4; 0 when none

Behaviour:
- Reset (async, rst=1): state=IDLE; T=0, N_q=0, all counters 0, busy=0, game_over=0, winner=0.
- All outputs are registered. An update is visible the cycle after the accepting clock edge.
- States:
  - IDLE: waits for start.
  - PLAY: accepts steps.
  - DONE: holds all values.
- start with N!=2'b11, any state (including PLAY/DONE, i.e. restart mid-game):
  - Next cycle: N_q=N, T=0, all four counters 0, winner=0, state=PLAY.
- start with N=2'b11: ignored; no state change.
- start and step_valid in the same cycle: start wins; the step is dropped.
- Turn-to-player mapping with last = N_q+1:
  - If T==last, the target is p1.
  - Otherwise the target is p(T+2).
  - So N_q=00: T0->p2, T1->p1. N_q=01: T0->p2, T1->p3, T2->p1. N_q=10: T0->p2, T1->p3, T2->p4, T3->p1.
- step_valid in PLAY:
  - sum = target + step_amt, computed at CNT_W+1 bits.
  - New target = min(sum, WIN_SCORE).
  - If sum >= WIN_SCORE: state=DONE, game_over=1, busy=0, winner=target player number. T is not advanced (it remains on the winner's turn).
  - Otherwise: T = (T==last) ? 0 : T+1 (wrap-around).
  - step_amt=0 still advances T.
- step_valid in IDLE or DONE: ignored.
- Non-participating counters (e.g. p3, p4 when N_q=00) stay 0 for the whole game.
- T never exceeds last.
- N input changes while in PLAY have no effect; only N_q is used.
- Counters never exceed WIN_SCORE. Requirement: WIN_SCORE <= 2^CNT_W-1.

Test Plan:
- Reset then start N=00:
  - Steps 3,4,5 -> p2=3 (T0->1), p1=4 (T1->0), p2=8, T=1.
  - p3, p4 = 0.
- N=10 full rotation with steps 1,2,3,4 -> p2=1, p3=2, p4=3, p1=4, T back to 0.
  - A fifth step of 7 gives p2=8, T=1.
- Win/saturation, N=01, WIN_SCORE=20:
  - Preload p2 to 18 via steps, then on p2's turn step 7 -> p2=20, winner=2, game_over=1, T unchanged.
  - A further step_valid causes no change.
- start N=11 from IDLE -> busy stays 0.
- start N=01 in the same cycle as step_valid during PLAY -> all counters 0, T=0, N_q=01.
- Async reset mid-game:
  - Assert rst between clock edges -> outputs 0 immediately.
  - Deassert, then step_valid -> ignored, since the state is IDLE.
